// File: rtl/bus_master_if.sv
// Command, response and bus-strobe bundle for bus_master.
// master: block side; slave: host and responder side.
interface bus_master_if;
  logic        CmdValid;
  logic        CmdReady;
  logic        CmdWrite;
  logic [15:0] CmdAddress;
  logic [7:0]  CmdData;
  logic        RespValid;
  logic [7:0]  RespData;
  logic        Busy;
  logic [15:0] BusAddress;
  logic        BusReadWrite;
  logic        BusClock;

  modport master (
    input  CmdValid,
    input  CmdWrite,
    input  CmdAddress,
    input  CmdData,
    output CmdReady,
    output RespValid,
    output RespData,
    output Busy,
    output BusAddress,
    output BusReadWrite,
    output BusClock
  );

  modport slave (
    output CmdValid,
    output CmdWrite,
    output CmdAddress,
    output CmdData,
    input  CmdReady,
    input  RespValid,
    input  RespData,
    input  Busy,
    input  BusAddress,
    input  BusReadWrite,
    input  BusClock
  );
endinterface

// File: rtl/bus_master.sv
// Single-beat initiator for the 8-bit synth register bus.
// Ports: Clock, Reset, bus (cmd/resp/strobes), BusData (shared).
module bus_master #(
  parameter  int HALF_PERIOD = 2,
  localparam int CNT_W = $clog2(HALF_PERIOD + 1)
) (
  input  logic         Clock,
  input  logic         Reset,
  bus_master_if.master bus,
  inout  wire  [7:0]   BusData
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LOAD =
    CNT_W'(HALF_PERIOD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             rw_q, rw_d;
  logic             clk_q, clk_d;
  logic             rv_q, rv_d;
  logic [7:0]       rd_q, rd_d;
  logic             done;
  logic             accept;
  logic             bus_oe;

  assign done   = (cnt_q == '0);
  assign accept = bus.CmdValid & bus.CmdReady;
  // The master only owns BusData while signalling a write.
  assign bus_oe = rw_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 16'h0000;
      data_q  <= 8'h00;
      rw_q    <= 1'b1;
      clk_q   <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      clk_q   <= clk_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = LOAD;
        end
      end
      SETUP: begin
        if (done) begin
          state_d = HIGH;
          cnt_d   = LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HIGH: begin
        if (done) begin
          state_d = HOLD;
          cnt_d   = LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered bus outputs, keyed to
  // the phase boundary that is about to be crossed.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    rw_d   = rw_q;
    clk_d  = clk_q;
    rv_d   = 1'b0;
    rd_d   = rd_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = bus.CmdAddress;
          rw_d   = bus.CmdWrite;
          if (bus.CmdWrite) begin
            data_d = bus.CmdData;
          end
        end
      end
      SETUP: begin
        if (done) begin
          clk_d = 1'b1;
        end
      end
      HIGH: begin
        if (done) begin
          clk_d = 1'b0;
          if (!rw_q) begin
            rv_d = 1'b1;
            rd_d = BusData;
          end
        end
      end
      HOLD: begin
        if (done) begin
          rw_d = 1'b1;
        end
      end
      default: begin
        clk_d = 1'b0;
        rw_d  = 1'b1;
      end
    endcase
  end

  assign BusData = bus_oe ? data_q : 8'hzz;

  assign bus.CmdReady     = (state_q == IDLE) & ~Reset;
  assign bus.Busy         = (state_q != IDLE);
  assign bus.RespValid    = rv_q;
  assign bus.RespData     = rd_q;
  assign bus.BusAddress   = addr_q;
  assign bus.BusReadWrite = rw_q;
  assign bus.BusClock     = clk_q;

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Initiator for the 8-bit synth register bus (BusAddress/BusData/BusReadWrite/BusClock); the opposite end of the per-channel register responders.
- Accepts single-beat read/write commands from a host-side source (UART bridge or sequencer) on a valid/ready interface.
- Generates one BusClock pulse per command from the system Clock and returns read data on a one-cycle response strobe.

Parameters:
- HALF_PERIOD, 2, Clock cycles per bus phase (SETUP, HIGH, HOLD); legal range ≥1.
- CNT_W, $clog2(HALF_PERIOD+1), width of the phase counter (derived; not overridden).

Ports:
- Clock  input  1  system clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-high reset.
- CmdValid  input  1  command present.
- CmdReady  output  1  block can accept a command.
- CmdWrite  input  1  1=write, 0=read.
- CmdAddress  input  16  target register address.
- CmdData  input  8  write data; ignored for reads.
- RespValid  output  1  one-cycle strobe, read data valid.
- RespData  output  8  captured read data.
- Busy  output  1  transaction in progress (state≠IDLE).
- BusAddress  output  16  bus address.
- BusData  inout  8  bus data; driven by master only when BusReadWrite=1.
- BusReadWrite  output  1  1=write, 0=read (responders drive BusData while 0).
- BusClock  output  1  bus strobe; responders act on its rising edge.

Behaviour:
Reset (asynchronous, immediate, also mid-transaction):
- state=IDLE, counter=0, BusClock=0, BusReadWrite=1, BusAddress=0, master drives BusData=8'h00.
- RespValid=0, RespData=0, CmdReady=0 while Reset is high, Busy=0.

States: IDLE, SETUP, HIGH, HOLD.
- IDLE:
  - CmdReady=1; BusClock=0; BusReadWrite=1; BusAddress and driven BusData hold their last values.
  - CmdValid&CmdReady at edge k: latch CmdWrite/CmdAddress/CmdData and enter SETUP at edge k.
- SETUP:
  - H=HALF_PERIOD cycles. BusAddress=latched address, BusReadWrite=latched write.
  - Write: BusData=latched data. Read: BusData=Z.
  - BusClock=0.
- HIGH: H cycles, BusClock=1, all other bus outputs unchanged. BusClock rises at edge k+H.
- HOLD:
  - H cycles, BusClock=0, address/RW/data held for responder hold time.
  - Entered at edge k+2H. Read: RespData←BusData and RespValid=1 for exactly one cycle, both at edge k+2H.
- Return: at edge k+3H, state=IDLE and BusReadWrite=1; the master re-drives BusData with the latched value.

Rules:
- Bus outputs and BusClock come from registers; no combinational path from command inputs to the bus.
- BusReadWrite changes only while BusClock=0, never in the same cycle as a BusClock edge.
- The master never drives BusData while BusReadWrite=0; both sides never drive BusData at once.
- CmdReady=(state==IDLE)&~Reset. Throughput is one command per 3H+1 cycles. CmdValid held high → next accept at edge k+3H+1.
- Command inputs are ignored outside the accept cycle; changing them mid-transaction has no effect.
- Read of an unmapped address: BusData floats. RespData captures the resolved value; the bench uses a tri0 pulldown, giving 8'h00.
- The counter counts down from H-1 and advances state at 0. H=1 gives single-cycle phases.

Test Plan:
- H=2, one channel responder at ADDR=0. Write addr 0x0001 data 0x5A accepted at edge k:
  - BusClock high at edges k+2..k+3, BusReadWrite=1, BusData=0x5A throughout.
  - Responder incr=0x5A; CmdReady returns at k+6.
- Read addr 0x0001 after that write:
  - BusData=Z from the master during SETUP..HOLD.
  - RespValid=1 for one cycle at edge k+4, RespData=0x5A.
- Back-to-back, CmdValid held, write 0x0002=0x01 then read 0x0002:
  - Second accept at k+7. RespData=0x01. BusReadWrite never toggles while BusClock=1.
- Reset asserted mid-HIGH of a write:
  - BusClock=0, BusReadWrite=1, BusAddress=0 immediately, without waiting for a Clock edge.
  - After release: CmdReady=1, RespValid=0, no further BusClock pulse.
- H=1, read unmapped 0x1234 with pulldown:
  - RespValid at edge k+2, RespData=0x00, CmdReady at k+3.
- Continuous bus-contention check on every test: assert on any X on BusData while BusReadWrite=1, and on any master drive while BusReadWrite=0.
